interval_chain_adder: RTL and testbench

Streaming chained adder for the interval-arithmetic datapath. It accepts signed operands one per handshake, accumulates them into a range-clamped running sum, and emits one result per chain. A chain closes after NUM_TERMS operands or at the first operand flagged last. The interval test benches drive this block as the device under test.

---
 rtl/ica_pkg.sv | 21 ++
 rtl/ica_clamp.sv | 22 ++
 rtl/interval_chain_adder.sv | 128 ++++++++++++
 tb/tb_interval_chain_adder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ica_pkg.sv
// rtl/ica_pkg.sv - shared types, widths and clamp helper for interval_chain_adder
package ica_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int COUNT_W = 4;

    function automatic int clamp_int(input int sum, input int lo, input int hi);
        if (sum < lo) begin
            return lo;
        end else if (sum > hi) begin
            return hi;
        end
        return sum;
    endfunction

endpackage

// File: rtl/ica_clamp.sv
// rtl/ica_clamp.sv - clamps a one-bit-wider running sum into [LO,HI] and flags clipping
module ica_clamp
    import ica_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int LO    = -1000,
    parameter int HI    = 1000
) (
    input  logic signed [ACC_W:0]   sum_i,
    output logic        [ACC_W-1:0] value_o,
    output logic                    clipped_o
);

    int sum_int;

    always_comb begin
        sum_int   = int'(sum_i);
        value_o   = ACC_W'(clamp_int(sum_int, LO, HI));
        clipped_o = (sum_int < LO) || (sum_int > HI);
    end

endmodule

// File: rtl/interval_chain_adder.sv
// rtl/interval_chain_adder.sv - streaming clamped chain adder; ICA_CLIP_FLAG_EN adds out_clipped
module interval_chain_adder
    import ica_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 12,
    parameter int NUM_TERMS = 4,
    parameter int LO        = -1000,
    parameter int HI        = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count
`ifdef ICA_CLIP_FLAG_EN
    ,
    output logic               out_clipped
`endif
);

    state_e               state_q;
    logic [ACC_W-1:0]     acc_q;
    logic [COUNT_W-1:0]   cnt_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic                 accept;
    logic                 drain;
    logic                 closes;
    logic [COUNT_W-1:0]   cnt_inc;
    logic signed [ACC_W:0] sum;
    logic [ACC_W-1:0]     clamp_val;
    logic                 clamp_clip;

    // in_ready_q is only high in IDLE/ACC and out_valid_q only in OUT,
    // so the handshakes need no extra state qualification.
    assign accept  = in_valid & in_ready_q;
    assign drain   = out_valid_q & out_ready;
    assign cnt_inc = cnt_q + COUNT_W'(1);
    assign closes  = in_last || (cnt_inc == COUNT_W'(NUM_TERMS));
    assign sum     = $signed({acc_q[ACC_W-1], acc_q})
                   + $signed({{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data});

    ica_clamp #(
        .ACC_W (ACC_W),
        .LO    (LO),
        .HI    (HI)
    ) u_clamp (
        .sum_i     (sum),
        .value_o   (clamp_val),
        .clipped_o (clamp_clip)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q <= clamp_val;
                        cnt_q <= cnt_inc;
                        if (closes) begin
                            state_q     <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                OUT: begin
                    if (drain) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = cnt_q;

`ifdef ICA_CLIP_FLAG_EN
    logic clip_q;

    // Sticky across the chain: any clamped intermediate sum marks the result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clip_q <= 1'b0;
        end else if (drain) begin
            clip_q <= 1'b0;
        end else if (accept && clamp_clip) begin
            clip_q <= 1'b1;
        end
    end

    assign out_clipped = clip_q;
`else
    logic unused_clamp_clip;
    assign unused_clamp_clip = clamp_clip;
`endif

endmodule

// File: tb/tb_interval_chain_adder.sv
// tb/tb_interval_chain_adder.sv - scoreboard bench: two instances (wide and narrow interval) in lockstep
module tb_interval_chain_adder;

    localparam int NT  = 4;
    localparam int LO0 = -1000;
    localparam int HI0 = 1000;
    localparam int LO1 = -100;
    localparam int HI1 = 100;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready [2];
    logic        out_valid [2];
    logic [11:0] od [2];
    logic [3:0]  ocnt [2];
`ifdef ICA_CLIP_FLAG_EN
    logic        ocl [2];
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;
    bit rand_ready = 0;
    bit was_valid = 0;
    int first_cyc = 0;

    typedef struct {
        int d0;
        int d1;
        int c0;
        int c1;
        int count;
        int close_cyc;
    } exp_t;

    exp_t expq [$];
    int   chain [$];

    always #5 clock = ~clock;

    interval_chain_adder #(.IN_W(8), .ACC_W(12), .NUM_TERMS(NT), .LO(LO0), .HI(HI0)) u0 (
        .clock(clock), .reset(resetn), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_count(ocnt[0])
`ifdef ICA_CLIP_FLAG_EN
        , .out_clipped(ocl[0])
`endif
    );

    interval_chain_adder #(.IN_W(8), .ACC_W(12), .NUM_TERMS(NT), .LO(LO1), .HI(HI1)) u1 (
        .clock(clock), .reset(resetn), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_count(ocnt[1])
`ifdef ICA_CLIP_FLAG_EN
        , .out_clipped(ocl[1])
`endif
    );

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void eval(input int lo, input int hi, output int s, output int c);
        s = 0;
        c = 0;
        foreach (chain[i]) begin
            s = s + chain[i];
            if (s < lo) begin
                s = lo;
                c = 1;
            end else if (s > hi) begin
                s = hi;
                c = 1;
            end
        end
    endfunction

    task automatic model_accept(input int v, input bit last);
        exp_t e;
        chain.push_back(v);
        if (last || chain.size() == NT) begin
            eval(LO0, HI0, e.d0, e.c0);
            eval(LO1, HI1, e.d1, e.c1);
            e.count = chain.size();
            e.close_cyc = cyc;
            expq.push_back(e);
            chain.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int v, input bit last);
        int n = 0;
        bit ok = 0;
        in_valid = 1'b1;
        in_data = v[7:0];
        in_last = last;
        while (n < 50) begin
            @(negedge clock);
            if (in_ready[0]) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clock);
        if (ok) model_accept(v, last);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (n < 200 && (expq.size() != 0 || out_valid[0])) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("drain_timeout", expq.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        resetn = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clock);
        chain.delete();
        expq.delete();
        was_valid = 0;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", in_ready[k], 0);
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_out_data", od[k], 0);
            chk("rst_out_count", ocnt[k], 0);
`ifdef ICA_CLIP_FLAG_EN
            chk("rst_out_clipped", ocl[k], 0);
`endif
        end
        resetn = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_in_ready", in_ready[k], 1);
            chk("post_rst_out_valid", out_valid[k], 0);
        end
        mon_en = 1;
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clock) begin
        cyc++;
        if (mon_en) begin
            chk("u0_ready_vs_valid", in_ready[0], !out_valid[0]);
            chk("u1_ready_vs_valid", in_ready[1], !out_valid[1]);
            if (out_valid[0]) begin
                if (expq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    if (!was_valid) begin
                        first_cyc = cyc;
                        chk("latency", first_cyc, expq[0].close_cyc + 1);
                    end
                    chk("u1_valid", out_valid[1], 1);
                    chk("u0_data", int'($signed(od[0])), expq[0].d0);
                    chk("u1_data", int'($signed(od[1])), expq[0].d1);
                    chk("u0_count", ocnt[0], expq[0].count);
                    chk("u1_count", ocnt[1], expq[0].count);
`ifdef ICA_CLIP_FLAG_EN
                    chk("u0_clipped", ocl[0], expq[0].c0);
                    chk("u1_clipped", ocl[1], expq[0].c1);
`endif
                    if (out_ready) begin
                        void'(expq.pop_front());
                        was_valid = 0;
                    end else begin
                        was_valid = 1;
                    end
                end
            end else begin
                was_valid = 0;
            end
        end
    end

    initial begin
        int v;
        do_reset();

        out_ready = 1'b1;
        send(10, 0); send(20, 0); send(30, 0); send(40, 0);
        wait_drain();

        send(5, 0); send(-7, 1);
        send(3, 1);
        wait_drain();

        send(127, 0); send(127, 0); send(-50, 1);
        wait_drain();

        send(-128, 0); send(-128, 0); send(-128, 0); send(-128, 0);
        wait_drain();

        // Backpressure: a held operand must not enter while the result waits.
        out_ready = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        in_valid = 1'b1;
        in_data = 8'd99;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_in_ready", in_ready[0], 0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(99, 1);
        wait_drain();

        send(50, 0); send(60, 0);
        do_reset();
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        wait_drain();

        out_ready = 1'b0;
        send(7, 1);
        repeat (3) @(posedge clock);
        #1;
        do_reset();
        out_ready = 1'b1;
        send(-3, 1);
        wait_drain();

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            v = int'($urandom_range(0, 255)) - 128;
            send(v, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        rand_ready = 0;
        #2;
        out_ready = 1'b1;
        if (chain.size() != 0) send(0, 1);
        wait_drain();
        chk("scoreboard_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
